// File: rtl/inst_encoder_if.sv
// Byte-stream bundle between an instruction source, the Y86 encoder and the
// instruction-memory loader. The slave modport is the encoder's view.
interface inst_encoder_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) ();
  // Handshake rule on both sides: a transfer happens on the rising clock edge
  // where valid and ready are both high; valid-side data must hold while ready is low.
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        icode;
  logic [3:0]        ifun;
  logic [3:0]        rA;
  logic [3:0]        rB;
  logic [31:0]       valC;
  logic              addr_load;
  logic [ADDR_W-1:0] addr_in;
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        out_byte;
  logic [ADDR_W-1:0] out_addr;
  logic              out_last;
  logic              err;
  logic [CNT_W-1:0]  inst_count;
  logic              state_dbg;

  modport slave (
    input  in_valid, icode, ifun, rA, rB, valC, addr_load, addr_in, out_ready,
    output in_ready, out_valid, out_byte, out_addr, out_last, err, inst_count, state_dbg
  );

  modport master (
    output in_valid, icode, ifun, rA, rB, valC, addr_load, addr_in, out_ready,
    input  in_ready, out_valid, out_byte, out_addr, out_last, err, inst_count, state_dbg
  );
endinterface

// File: rtl/inst_encoder.sv
// Y86 instruction encoder: latches one decoded instruction and streams its
// architectural byte encoding (1/2/5/6 bytes) with a running byte address.
module inst_encoder #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input logic           clk,
  input logic           rst,
  inst_encoder_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t            state, state_nx;
  logic [3:0]        icode_q, ifun_q, ra_q, rb_q;
  logic [31:0]       valc_q;
  logic [2:0]        idx;
  logic [2:0]        len;
  logic [7:0]        byte_sel;
  logic [2:0]        cidx;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  count_q;
  logic              err_q;
  logic              legal;
  logic              accept;
  logic              consume;
  logic              is_last;

  assign legal   = (bus.icode <= 4'hB);
  assign accept  = (state == IDLE) && bus.in_valid;
  assign consume = (state == EMIT) && bus.out_ready;
  assign is_last = (idx == (len - 3'd1));

  always_comb begin
    len = 3'd1;
    case (icode_q)
      4'h0, 4'h1, 4'h9:       len = 3'd1;
      4'h2, 4'h6, 4'hA, 4'hB: len = 3'd2;
      4'h7, 4'h8:             len = 3'd5;
      4'h3, 4'h4, 4'h5:       len = 3'd6;
      default:                len = 3'd1;
    endcase
  end

  // jXX/call put valC right after the opcode byte; 6-byte forms after the register byte.
  always_comb begin
    byte_sel = 8'h00;
    cidx     = (len == 3'd5) ? (idx - 3'd1) : (idx - 3'd2);
    if (idx == 3'd0) begin
      byte_sel = {icode_q,
                  (icode_q == 4'h2 || icode_q == 4'h6 || icode_q == 4'h7) ? ifun_q : 4'h0};
    end else if (len != 3'd5 && idx == 3'd1) begin
      byte_sel = {(icode_q == 4'h3) ? 4'hF : ra_q,
                  (icode_q == 4'hA || icode_q == 4'hB) ? 4'hF : rb_q};
    end else begin
      byte_sel = valc_q[{cidx[1:0], 3'b000} +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.in_valid && legal) state_nx = EMIT;
      EMIT:    if (bus.out_ready && is_last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      icode_q <= 4'h0;
      ifun_q  <= 4'h0;
      ra_q    <= 4'h0;
      rb_q    <= 4'h0;
      valc_q  <= 32'h0;
      idx     <= 3'd0;
      addr_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= accept && !legal;
      if (accept) begin
        icode_q <= bus.icode;
        ifun_q  <= bus.ifun;
        ra_q    <= bus.rA;
        rb_q    <= bus.rB;
        valc_q  <= bus.valC;
        idx     <= 3'd0;
      end else if (consume) begin
        idx <= idx + 3'd1;
      end
      // A load shares the IDLE cycle with acceptance, so byte 0 lands at addr_in.
      if (state == IDLE && bus.addr_load) addr_q <= bus.addr_in;
      else if (consume)                   addr_q <= addr_q + 1'b1;
      if (consume && is_last) count_q <= count_q + 1'b1;
    end
  end

  assign bus.in_ready   = (state == IDLE);
  assign bus.out_valid  = (state == EMIT);
  assign bus.out_byte   = (state == EMIT) ? byte_sel : 8'h00;
  assign bus.out_last   = (state == EMIT) && is_last;
  assign bus.out_addr   = addr_q;
  assign bus.err        = err_q;
  assign bus.inst_count = count_q;
  assign bus.state_dbg  = state;

endmodule

// File: tb/tb_inst_encoder.sv
// Bench for inst_encoder: random and directed instructions against a byte-list
// reference model; a monitor checks every presented byte against a queue.
module tb_inst_encoder;
  localparam int W = 41; // {last, addr[31:0], byte[7:0]}

  logic clk;
  logic rst;
  inst_encoder_if #(.ADDR_W(32), .CNT_W(16)) bus ();

  inst_encoder #(.ADDR_W(32), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests;
  int fails;
  logic [W-1:0] exp_q[$];
  logic [31:0] tb_addr;
  int model_count;
  int popped;
  int errs_seen;
  int exp_err;
  int rdy_mode;
  int rdy_phase;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    tests++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s got %0h required %0h", name, got, req);
    end
  endtask

  // ---------------- out_ready generator ----------------
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.out_ready = 1'b1;
        1:       begin bus.out_ready = (rdy_phase % 3 == 0); rdy_phase++; end
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        if (bus.err) errs_seen++;
        if (bus.out_valid) begin
          if (exp_q.size() == 0) begin
            check("unexpected_byte", {23'd0, bus.out_last, bus.out_addr, bus.out_byte}, 64'hDEAD);
          end else begin
            check("byte_stream", {23'd0, bus.out_last, bus.out_addr, bus.out_byte},
                  {23'd0, exp_q[0]});
            if (bus.out_ready) begin
              if (exp_q[0][W-1]) model_count++;
              void'(exp_q.pop_front());
              popped++;
            end
          end
        end
      end
    end
  end

  // ---------------- reference model + driver ----------------
  function automatic int enc_len(input logic [3:0] ic);
    if (ic inside {4'h0, 4'h1, 4'h9}) return 1;
    if (ic inside {4'h2, 4'h6, 4'hA, 4'hB}) return 2;
    if (ic inside {4'h7, 4'h8}) return 5;
    return 6;
  endfunction

  task automatic send(input logic [3:0] ic, input logic [3:0] f, input logic [3:0] a,
                      input logic [3:0] rb, input logic [31:0] c,
                      input bit ld, input logic [31:0] la);
    int n;
    int len;
    logic [7:0] b;
    n = 0;
    while (!bus.in_ready && n < 200) begin
      n++;
      @(posedge clk); #1;
    end
    if (n >= 200) check("in_ready_timeout", 64'd0, 64'd1);
    bus.icode = ic; bus.ifun = f; bus.rA = a; bus.rB = rb; bus.valC = c;
    bus.in_valid = 1'b1;
    bus.addr_load = ld;
    bus.addr_in = la;
    if (ld) tb_addr = la;
    if (ic <= 4'hB) begin
      len = enc_len(ic);
      for (int i = 0; i < len; i++) begin
        if (i == 0)             b = {ic, (ic == 4'h2 || ic == 4'h6 || ic == 4'h7) ? f : 4'h0};
        else if (len == 5)      b = 8'(c >> (8 * (i - 1)));
        else if (i == 1)        b = {(ic == 4'h3) ? 4'hF : a, (ic == 4'hA || ic == 4'hB) ? 4'hF : rb};
        else                    b = 8'(c >> (8 * (i - 2)));
        exp_q.push_back({(i == len - 1), tb_addr + 32'(i), b});
      end
      tb_addr = tb_addr + 32'(len);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.addr_load = 1'b0;
    if (ic > 4'hB) begin
      exp_err++;
      check("err_pulse", {63'd0, bus.err}, 64'd1);
      check("err_no_valid", {63'd0, bus.out_valid}, 64'd0);
      @(posedge clk); #1;
      check("err_one_cycle", {63'd0, bus.err}, 64'd0);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(bus.in_ready && exp_q.size() == 0) && n < 500) begin
      n++;
      @(posedge clk); #1;
    end
    if (n >= 500) check("idle_timeout", 64'(exp_q.size()), 64'd0);
    check("out_addr", {32'd0, bus.out_addr}, {32'd0, tb_addr});
    check("inst_count", {48'd0, bus.inst_count}, 64'(16'(model_count)));
  endtask

  task automatic load_addr(input logic [31:0] a);
    bus.addr_load = 1'b1;
    bus.addr_in = a;
    @(posedge clk); #1;
    bus.addr_load = 1'b0;
    tb_addr = a;
  endtask

  initial begin
    int n;
    int base;
    tests = 0; fails = 0; model_count = 0; popped = 0;
    errs_seen = 0; exp_err = 0; rdy_mode = 0; rdy_phase = 0; tb_addr = 32'd0;
    rst = 1'b0;
    bus.in_valid = 1'b0; bus.icode = 4'h0; bus.ifun = 4'h0; bus.rA = 4'h0; bus.rB = 4'h0;
    bus.valC = 32'h0; bus.addr_load = 1'b0; bus.addr_in = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("rst_out_byte", {56'd0, bus.out_byte}, 64'd0);
    check("rst_out_last", {63'd0, bus.out_last}, 64'd0);
    check("rst_err", {63'd0, bus.err}, 64'd0);
    check("rst_out_addr", {32'd0, bus.out_addr}, 64'd0);
    check("rst_inst_count", {48'd0, bus.inst_count}, 64'd0);

    // irmovl at 0x100, full-rate consumer
    load_addr(32'h100);
    send(4'h3, 4'h0, 4'h2, 4'h0, 32'h1234_5678, 1'b0, 32'h0);
    n = 0;
    while (!bus.in_ready && n < 50) begin
      n++;
      @(posedge clk); #1;
    end
    check("in_ready_low_cycles", 64'(n), 64'd6);
    wait_idle();

    // rrmovl then pushl, back to back
    send(4'h2, 4'h0, 4'h1, 4'h3, 32'h0, 1'b0, 32'h0);
    send(4'hA, 4'h0, 4'h6, 4'h0, 32'h0, 1'b0, 32'h0);
    wait_idle();

    // jmp with a stalling consumer
    rdy_mode = 1; rdy_phase = 0;
    send(4'h7, 4'h0, 4'h0, 4'h0, 32'h100, 1'b0, 32'h0);
    wait_idle();
    rdy_mode = 0;

    // ret with nonzero ifun, then halt
    send(4'h9, 4'h5, 4'h0, 4'h0, 32'h0, 1'b0, 32'h0);
    send(4'h0, 4'h0, 4'h0, 4'h0, 32'h0, 1'b0, 32'h0);
    wait_idle();

    // invalid icode, then a valid nop
    send(4'hD, 4'h0, 4'h0, 4'h0, 32'h0, 1'b0, 32'h0);
    wait_idle();
    send(4'h1, 4'h3, 4'h0, 4'h0, 32'h0, 1'b0, 32'h0);
    wait_idle();

    // address wrap across 2^32 with a coincident load
    send(4'h8, 4'h0, 4'h0, 4'h0, $urandom, 1'b1, 32'hFFFF_FFFE);
    wait_idle();

    // addr_load during EMIT must be ignored
    send(4'h7, 4'h4, 4'h0, 4'h0, $urandom, 1'b0, 32'h0);
    bus.addr_load = 1'b1;
    bus.addr_in = 32'hCAFE_0000;
    repeat (2) begin @(posedge clk); #1; end
    bus.addr_load = 1'b0;
    wait_idle();

    // reset in the middle of mrmovl
    base = popped;
    send(4'h5, 4'h0, 4'h3, 4'h4, 32'hAABB_CCDD, 1'b0, 32'h0);
    n = 0;
    while (popped < base + 3 && n < 50) begin
      n++;
      @(posedge clk); #1;
    end
    #2;
    rst = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    check("mid_rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    rst = 1'b1;
    tb_addr = 32'd0;
    model_count = 0;
    @(posedge clk); #1;
    check("post_rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("post_rst_out_addr", {32'd0, bus.out_addr}, 64'd0);
    check("post_rst_inst_count", {48'd0, bus.inst_count}, 64'd0);
    check("post_rst_in_ready", {63'd0, bus.in_ready}, 64'd1);

    // randomized traffic
    for (int k = 0; k < 40; k++) begin
      rdy_mode = $urandom_range(0, 2);
      send(4'($urandom_range(0, 15)), 4'($urandom), 4'($urandom), 4'($urandom), $urandom,
           ($urandom_range(0, 4) == 0), $urandom);
      wait_idle();
    end

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    check("err_pulses", 64'(errs_seen), 64'(exp_err));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
